// File: rtl/top_seq_pkg.sv
// Shared constants for the sequential accumulate block: one-hot step
// indices, the step enum built from them, and default datapath settings.
package top_seq_pkg;
  localparam int START   = 0;
  localparam int S1      = 1;
  localparam int S2      = 2;
  localparam int DONE    = 3;
  localparam int N_STEPS = 4;

  localparam int DEF_W      = 8;
  localparam int DEF_INIT_A = 24;
  localparam int DEF_INIT_B = 12;

  typedef enum logic [N_STEPS-1:0] {
    ST_START = N_STEPS'(1 << START),
    ST_S1    = N_STEPS'(1 << S1),
    ST_S2    = N_STEPS'(1 << S2),
    ST_DONE  = N_STEPS'(1 << DONE)
  } step_t;
endpackage

// File: rtl/top_seq_accum_seq_ctrl.sv
// One-hot step sequencer: START -> S1 -> S2 -> DONE, parks in DONE until rst.
module seq_ctrl
  import top_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic en_s0,
  output logic en_s1,
  output logic en_s2,
  output logic done
);
  step_t state, nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_START;
    else     state <= nxt;
  end

  always_comb begin
    nxt   = state;
    en_s0 = 1'b0;
    en_s1 = 1'b0;
    en_s2 = 1'b0;
    done  = 1'b0;
    case (state)
      ST_START: begin en_s0 = 1'b1; nxt = ST_S1;   end
      ST_S1:    begin en_s1 = 1'b1; nxt = ST_S2;   end
      ST_S2:    begin en_s2 = 1'b1; nxt = ST_DONE; end
      ST_DONE:  begin done  = 1'b1; nxt = ST_DONE; end
      // a corrupted encoding falls back to a clean restart
      default:  nxt = ST_START;
    endcase
  end
endmodule

// File: rtl/top_seq_accum.sv
// Runs a fixed program once after reset: load a/b, add b into a twice,
// snapshot the final sum into c, then hold all registers.
module top_seq_accum
  import top_seq_pkg::*;
#(
  parameter int unsigned W      = DEF_W,
  parameter int unsigned INIT_A = DEF_INIT_A,
  parameter int unsigned INIT_B = DEF_INIT_B
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c
);
  logic         en_s0, en_s1, en_s2, done;
  logic [W-1:0] sum;

  seq_ctrl u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .en_s0 (en_s0),
    .en_s1 (en_s1),
    .en_s2 (en_s2),
    .done  (done)
  );

  // single shared adder; carry out of the top bit is dropped (mod 2^W)
  assign sum = a + b;

  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      c <= '0;
    end else if (!done) begin
      if (en_s0) begin
        a <= W'(INIT_A);
        b <= W'(INIT_B);
      end
      if (en_s1 || en_s2) a <= sum;
      if (en_s2)          c <= sum;
    end
  end
endmodule

// File: tb/tb_top_seq_accum.sv
// Scoreboard bench: stimulus pushes hand-computed (a,b,c) for the default
// instance and a wrap-around instance; a negedge monitor pops and compares.
module tb_top_seq_accum;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a, b, c;
  logic [7:0] wa, wb, wc;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      name;
    logic [7:0] a, b, c, wa, wb, wc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  top_seq_accum dut (.clk(clk), .rst(rst), .a(a), .b(b), .c(c));
  top_seq_accum #(.W(8), .INIT_A(250), .INIT_B(12)) dut_w (
    .clk(clk), .rst(rst), .a(wa), .b(wb), .c(wc));

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // one rising edge with rst=r, then record what must be visible after it
  task automatic step(input logic r, input string nm,
                      input logic [7:0] ea, eb, ec, ewa, ewb, ewc);
    exp_t e;
    rst = r;
    @(posedge clk);
    e.name = nm;
    e.a = ea; e.b = eb; e.c = ec; e.wa = ewa; e.wb = ewb; e.wc = ewc;
    q.push_back(e);
    @(negedge clk);
  endtask

  bit seen_rst = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      seen_rst = 1'b1;
      chk({e.name, ".a"},  a,  e.a);
      chk({e.name, ".b"},  b,  e.b);
      chk({e.name, ".c"},  c,  e.c);
      chk({e.name, ".wa"}, wa, e.wa);
      chk({e.name, ".wb"}, wb, e.wb);
      chk({e.name, ".wc"}, wc, e.wc);
    end
    if (seen_rst) begin
      chk("onehot", 8'($onehot(dut.u_ctrl.state)), 8'd1);
      chk("onehot_w", 8'($onehot(dut_w.u_ctrl.state)), 8'd1);
    end
  end

  initial begin
    // scenario 1: single reset edge then the program
    step(1'b1, "rst",  0,  0,  0,   0,  0,  0);
    step(1'b0, "e1",  24, 12,  0, 250, 12,  0);
    step(1'b0, "e2",  36, 12,  0,   6, 12,  0);
    step(1'b0, "e3",  48, 12, 48,  18, 12, 18);
    // scenario 2: DONE holds
    for (int i = 0; i < 100; i++)
      step(1'b0, "hold", 48, 12, 48, 18, 12, 18);
    // scenario 3: long reset
    for (int i = 0; i < 5; i++)
      step(1'b1, "rst5", 0, 0, 0, 0, 0, 0);
    // scenario 4: reset right after edge 2, then full restart
    step(1'b0, "r1",  24, 12,  0, 250, 12,  0);
    step(1'b0, "r2",  36, 12,  0,   6, 12,  0);
    step(1'b1, "mid",  0,  0,  0,   0,  0,  0);
    step(1'b0, "p1",  24, 12,  0, 250, 12,  0);
    step(1'b0, "p2",  36, 12,  0,   6, 12,  0);
    step(1'b0, "p3",  48, 12, 48,  18, 12, 18);
    for (int i = 0; i < 4; i++)
      step(1'b0, "phold", 48, 12, 48, 18, 12, 18);

    repeat (2) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
